// File: rtl/lorenz_pkg.sv
// lorenz_pkg
//   Shared definitions for the Lorenz plotter slice: Q7.25 fixed-point
//   format constants, the plotter FSM state encoding, default screen
//   geometry, and a saturating 16-bit increment helper.
package lorenz_pkg;

  // Q7.25 signed state samples from the integrator
  localparam int Q_INT  = 7;
  localparam int Q_FRAC = 25;
  localparam int Q_W    = 32;

  // Default screen geometry and plot mapping
  localparam int DEF_H_RES   = 640;
  localparam int DEF_V_RES   = 480;
  localparam int DEF_ADDR_W  = 19;
  localparam int DEF_SHIFT   = 3;
  localparam int DEF_X_OFF   = 320;
  localparam int DEF_Z_OFF   = 440;
  localparam int DEF_COLOR_W = 8;

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_CLEAR = 3'd1,
    ST_IDLE  = 3'd2,
    ST_CALC  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  // Event counters stick at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lorenz_plotter_if.sv
// lorenz_plotter_if
//   Single-word framebuffer write channel (valid/ready).
//   fb_we    : write valid, driven by the master
//   fb_ready : sink accepts the write when fb_we && fb_ready
//   fb_addr  : pixel address row*H_RES + col
//   fb_data  : pixel value
interface lorenz_plotter_if #(
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 8
) ();
  logic               fb_we;
  logic               fb_ready;
  logic [ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0] fb_data;

  modport master (output fb_we, output fb_addr, output fb_data, input fb_ready);
  modport slave  (input fb_we, input fb_addr, input fb_data, output fb_ready);
endinterface

// File: rtl/lorenz_pixel_map.sv
// lorenz_pixel_map
//   Combinational projection of a captured (x, z) Q7.25 sample onto the
//   screen: scale by 2^SHIFT pixels per unit, offset to the origin pixel,
//   flag off-screen points and form the linear framebuffer address.
//   x, z : captured signed samples
//   addr : row*H_RES + col (meaningful only when clip = 0)
//   clip : point lies outside [0,H_RES) x [0,V_RES)
module lorenz_pixel_map
  import lorenz_pkg::*;
#(
  parameter int H_RES  = DEF_H_RES,
  parameter int V_RES  = DEF_V_RES,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SHIFT  = DEF_SHIFT,
  parameter int X_OFF  = DEF_X_OFF,
  parameter int Z_OFF  = DEF_Z_OFF
) (
  input  logic signed [Q_W-1:0] x,
  input  logic signed [Q_W-1:0] z,
  output logic [ADDR_W-1:0]     addr,
  output logic                  clip
);

  localparam int SH_AMT = Q_FRAC - SHIFT;

  logic signed [Q_W-1:0] xs_s;
  logic signed [Q_W-1:0] zs_s;
  logic signed [Q_W-1:0] col_s;
  logic signed [Q_W-1:0] row_s;

  // Scale, offset (screen rows grow downward, so z is subtracted), clip, address
  always_comb begin
    xs_s  = x >>> SH_AMT;
    zs_s  = z >>> SH_AMT;
    col_s = X_OFF + xs_s;
    row_s = Z_OFF - zs_s;
    clip  = (col_s < 32'sd0) || (col_s >= H_RES) ||
            (row_s < 32'sd0) || (row_s >= V_RES);
    addr  = ADDR_W'(row_s * H_RES + col_s);
  end

endmodule

// File: rtl/lorenz_plotter.sv
// lorenz_plotter
//   Plots Lorenz (x, z) samples into a framebuffer. After reset, or on
//   request, the whole framebuffer is first wiped to zero; afterwards each
//   accepted sample becomes one COLOR write at its projected pixel, unless
//   it falls off-screen.
//   clk, rst       : clock, asynchronous active-high reset
//   sample_en, x, z: sample strobe and Q7.25 signed state values
//   clear_req      : one-cycle wipe request (latched if not IDLE)
//   fb             : framebuffer write channel (master side)
//   busy           : FSM not IDLE
//   clear_done     : sticky wipe-complete flag, cleared when a wipe starts
//   drop_cnt       : samples ignored because not IDLE (saturating)
//   clip_cnt       : samples discarded as off-screen (saturating)
module lorenz_plotter
  import lorenz_pkg::*;
#(
  parameter int                 H_RES   = DEF_H_RES,
  parameter int                 V_RES   = DEF_V_RES,
  parameter int                 ADDR_W  = DEF_ADDR_W,
  parameter int                 SHIFT   = DEF_SHIFT,
  parameter int                 X_OFF   = DEF_X_OFF,
  parameter int                 Z_OFF   = DEF_Z_OFF,
  parameter int                 COLOR_W = DEF_COLOR_W,
  parameter logic [COLOR_W-1:0] COLOR   = COLOR_W'(8'hFF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_en,
  input  logic signed [Q_W-1:0] x,
  input  logic signed [Q_W-1:0] z,
  input  logic                  clear_req,
  lorenz_plotter_if.master      fb,
  output logic                  busy,
  output logic                  clear_done,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           clip_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  state_t                state_r;
  state_t                next_s;
  logic [ADDR_W-1:0]     addr_r;
  logic signed [Q_W-1:0] x_r;
  logic signed [Q_W-1:0] z_r;
  logic                  pend_r;
  logic                  clear_done_r;
  logic [15:0]           drop_r;
  logic [15:0]           clip_r;

  logic [ADDR_W-1:0]     pix_addr_s;
  logic                  pix_clip_s;
  logic                  we_s;
  logic [COLOR_W-1:0]    data_s;
  logic                  busy_s;
  logic                  accept_s;
  logic                  last_s;
  logic                  enter_clear_s;

  lorenz_pixel_map #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .ADDR_W(ADDR_W),
    .SHIFT (SHIFT),
    .X_OFF (X_OFF),
    .Z_OFF (Z_OFF)
  ) u_map (
    .x   (x_r),
    .z   (z_r),
    .addr(pix_addr_s),
    .clip(pix_clip_s)
  );

  assign accept_s      = we_s && fb.fb_ready;
  assign last_s        = (addr_r == LAST_ADDR);
  // A wipe always starts from address 0, whichever state it is entered from
  assign enter_clear_s = (next_s == ST_CLEAR) && (state_r != ST_CLEAR);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_START;
    end else begin
      state_r <= next_s;
    end
  end

  // FSM next-state decode; a sample wins over a clear, which then stays pending
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_START: next_s = ST_CLEAR;
      ST_CLEAR: begin
        if (accept_s && last_s) begin
          next_s = ST_IDLE;
        end else begin
          next_s = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        if (sample_en) begin
          next_s = ST_CALC;
        end else if (clear_req || pend_r) begin
          next_s = ST_CLEAR;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (pix_clip_s) begin
          next_s = ST_IDLE;
        end else begin
          next_s = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (fb.fb_ready) begin
          next_s = ST_IDLE;
        end else begin
          next_s = ST_WRITE;
        end
      end
      default: next_s = ST_START;
    endcase
  end

  // FSM output decode: write strobe, data and busy depend on state only
  always_comb begin
    we_s   = 1'b0;
    data_s = {COLOR_W{1'b0}};
    busy_s = 1'b1;
    case (state_r)
      ST_CLEAR: begin
        we_s   = 1'b1;
        data_s = {COLOR_W{1'b0}};
      end
      ST_WRITE: begin
        we_s   = 1'b1;
        data_s = COLOR;
      end
      ST_IDLE: busy_s = 1'b0;
      default: begin
        we_s   = 1'b0;
        data_s = {COLOR_W{1'b0}};
        busy_s = 1'b1;
      end
    endcase
  end

  // Address register: wipe counter in CLEAR, plotted pixel address in WRITE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r <= {ADDR_W{1'b0}};
    end else if (enter_clear_s) begin
      addr_r <= {ADDR_W{1'b0}};
    end else if ((state_r == ST_CLEAR) && accept_s && !last_s) begin
      addr_r <= addr_r + ADDR_W'(1);
    end else if ((state_r == ST_CALC) && !pix_clip_s) begin
      addr_r <= pix_addr_s;
    end else begin
      addr_r <= addr_r;
    end
  end

  // Sample capture, only when the plotter is free to take it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r <= {Q_W{1'b0}};
      z_r <= {Q_W{1'b0}};
    end else if ((state_r == ST_IDLE) && sample_en) begin
      x_r <= x;
      z_r <= z;
    end else begin
      x_r <= x_r;
      z_r <= z_r;
    end
  end

  // Pending-clear and wipe-complete flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r       <= 1'b0;
      clear_done_r <= 1'b0;
    end else if (enter_clear_s) begin
      pend_r       <= 1'b0;
      clear_done_r <= 1'b0;
    end else begin
      pend_r       <= pend_r | clear_req;
      clear_done_r <= clear_done_r | ((state_r == ST_CLEAR) && accept_s && last_s);
    end
  end

  // Saturating drop and clip counters, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_r <= 16'd0;
      clip_r <= 16'd0;
    end else begin
      if (sample_en && (state_r != ST_IDLE)) begin
        drop_r <= sat_inc16(drop_r);
      end else begin
        drop_r <= drop_r;
      end
      if ((state_r == ST_CALC) && pix_clip_s) begin
        clip_r <= sat_inc16(clip_r);
      end else begin
        clip_r <= clip_r;
      end
    end
  end

  assign fb.fb_we   = we_s;
  assign fb.fb_addr = addr_r;
  assign fb.fb_data = data_s;
  assign busy       = busy_s;
  assign clear_done = clear_done_r;
  assign drop_cnt   = drop_r;
  assign clip_cnt   = clip_r;

endmodule

// File: tb/tb_lorenz_plotter.sv
// tb_lorenz_plotter
//   Scoreboard bench for lorenz_plotter on a 16x8 screen (SHIFT=1,
//   origin at column 8, row 7). Expected writes are queued as stimulus is
//   issued; a negedge monitor pops and compares every accepted write and
//   checks that a stalled write holds still.
module tb_lorenz_plotter;

  localparam int H     = 16;
  localparam int V     = 8;
  localparam int AW    = 7;
  localparam int SH    = 1;
  localparam int XO    = 8;
  localparam int ZO    = 7;
  localparam int NPIX  = H * V;
  localparam int NRAND = 400;
  localparam int NDIR  = 10;

  typedef struct {
    int addr;
    int data;
    int exp_cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sample_en = 1'b0;
  logic               clear_req = 1'b0;
  logic signed [31:0] x = 32'sd0;
  logic signed [31:0] z = 32'sd0;
  logic               busy;
  logic               clear_done;
  logic [15:0]        drop_cnt;
  logic [15:0]        clip_cnt;

  lorenz_plotter_if #(.ADDR_W(AW), .COLOR_W(8)) fb ();

  lorenz_plotter #(
    .H_RES(H), .V_RES(V), .ADDR_W(AW), .SHIFT(SH),
    .X_OFF(XO), .Z_OFF(ZO), .COLOR_W(8), .COLOR(8'hFF)
  ) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .x(x), .z(z),
    .clear_req(clear_req), .fb(fb), .busy(busy), .clear_done(clear_done),
    .drop_cnt(drop_cnt), .clip_cnt(clip_cnt)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int addr, input int data, input int ec);
    exp_t e;
    e.addr = addr;
    e.data = data;
    e.exp_cyc = ec;
    sb_q.push_back(e);
  endtask

  task automatic push_wipe();
    for (int i = 0; i < NPIX; i++) push(i, 0, -1);
  endtask

  task automatic send(input logic [31:0] xv, input logic [31:0] zv);
    x = xv;
    z = zv;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  // Reference projection: real-valued state scaled to pixels, floored
  function automatic void pixel_ref(input int xv, input int zv, output bit clip, output int addr);
    real scale;
    int  col;
    int  row;
    scale = 2.0 ** (25 - SH);
    col   = XO + int'($floor($itor(xv) / scale));
    row   = ZO - int'($floor($itor(zv) / scale));
    clip  = (col < 0) || (col >= H) || (row < 0) || (row >= V);
    addr  = row * H + col;
  endfunction

  // Monitor: write ordering/content, first-valid cycle, and stall stability
  logic          prev_we = 1'b0;
  logic          prev_rdy = 1'b1;
  logic [AW-1:0] prev_addr = '0;
  logic [7:0]    prev_data = '0;
  int            start_cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_we  = 1'b0;
      prev_rdy = 1'b1;
    end else begin
      if (prev_we && !prev_rdy) begin
        chk("hold_we", fb.fb_we, 1);
        chk("hold_addr", fb.fb_addr, prev_addr);
        chk("hold_data", fb.fb_data, prev_data);
      end else if (fb.fb_we) begin
        start_cyc = cyc;
      end
      if (fb.fb_we && fb.fb_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: got addr %0d data %0d, expected none", fb.fb_addr, fb.fb_data);
        end else begin
          e = sb_q.pop_front();
          chk("wr_addr", fb.fb_addr, e.addr);
          chk("wr_data", fb.fb_data, e.data);
          if (e.exp_cyc >= 0) chk("wr_latency", start_cyc, e.exp_cyc);
        end
      end
      prev_we   = fb.fb_we;
      prev_rdy  = fb.fb_ready;
      prev_addr = fb.fb_addr;
      prev_data = fb.fb_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] dir_x [NDIR] = '{32'h00000000, 32'hFE000000, 32'h04000000, 32'h08000000, 32'h00000000,
                                32'h07FFFFFF, 32'hF8000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
  logic [31:0] dir_z [NDIR] = '{32'h00000000, 32'h00000000, 32'h02000000, 32'h00000000, 32'hFE000000,
                                32'h00000000, 32'h03800000, 32'h00000000, 32'h07000000, 32'h08000000};
  int          dir_a [NDIR] = '{120, 118, 92, -1, -1, 127, 64, 119, 8, -1};

  initial begin
    int r;
    int t0;
    int n;
    int c;
    int exp_drop;
    int exp_clip;
    int free_c;
    int base;
    int t;
    int xv;
    int zv;
    int pa;
    bit pc;
    bit se;
    bit rdy_tab [NRAND + 32];

    fb.fb_ready = 1'b1;
    exp_drop = 0;
    exp_clip = 0;

    // Reset state
    repeat (3) tick();
    chk("rst_we", fb.fb_we, 0);
    chk("rst_addr", fb.fb_addr, 0);
    chk("rst_data", fb.fb_data, 0);
    chk("rst_busy", busy, 1);
    chk("rst_clear_done", clear_done, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_clip", clip_cnt, 0);

    // Power-on wipe: 128 back-to-back zero writes, one sample dropped meanwhile
    push_wipe();
    rst = 1'b0;
    r = cyc;
    n = 0;
    while (!fb.fb_we && n < 10) begin tick(); n++; end
    t0 = cyc;
    chk("wipe_start_within_2", (t0 - r) <= 2, 1);
    repeat (5) tick();
    send(32'h0, 32'h0);
    exp_drop++;
    n = 0;
    while (!clear_done && n < 300) begin tick(); n++; end
    chk("wipe_cycles", cyc - t0, NPIX);
    chk("wipe_busy", busy, 0);
    chk("wipe_drop", drop_cnt, exp_drop);

    // Directed plots, boundaries and clips
    for (int i = 0; i < NDIR; i++) begin
      if (dir_a[i] >= 0) push(dir_a[i], 255, cyc + 2);
      else exp_clip++;
      send(dir_x[i], dir_z[i]);
      repeat (3) tick();
    end
    chk("dir_clip", clip_cnt, exp_clip);
    chk("dir_busy", busy, 0);

    // Back-pressure: WRITE stalled 5 cycles, two samples dropped meanwhile
    fb.fb_ready = 1'b0;
    c = cyc;
    push(122, 255, c + 2);
    send(32'h02000000, 32'h0);
    tick();
    send(32'h0, 32'h0);
    tick();
    send(32'h0, 32'h0);
    tick();
    exp_drop += 2;
    fb.fb_ready = 1'b1;
    repeat (3) tick();
    chk("bp_drop", drop_cnt, exp_drop);
    chk("bp_clip", clip_cnt, exp_clip);

    // clear_req during WRITE: write completes, then wipe from address 0
    chk("pre_clr_done", clear_done, 1);
    fb.fb_ready = 1'b0;
    c = cyc;
    push(116, 255, c + 2);
    send(32'hFC000000, 32'h0);
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    fb.fb_ready = 1'b1;
    push_wipe();
    repeat (3) tick();
    chk("clr_done_dropped", clear_done, 0);
    chk("clr_busy", busy, 1);
    n = 0;
    while (!clear_done && n < 300) begin tick(); n++; end
    chk("clr_done_set", clear_done, 1);
    repeat (2) tick();

    // Random samples and random back-pressure against the reference model
    for (int i = 0; i < NRAND + 32; i++) rdy_tab[i] = (i >= NRAND) ? 1'b1 : ($urandom_range(0, 3) != 0);
    base = cyc;
    free_c = base;
    for (int k = 0; k < NRAND; k++) begin
      c = cyc;
      fb.fb_ready = rdy_tab[k];
      se = ($urandom_range(0, 9) < 4);
      xv = int'($urandom_range(0, 10 * (1 << 25))) - 5 * (1 << 25);
      zv = int'($urandom_range(0, 6 * (1 << 25))) - (1 << 25);
      if (se) begin
        if (c < free_c) begin
          exp_drop++;
        end else begin
          pixel_ref(xv, zv, pc, pa);
          if (pc) begin
            exp_clip++;
            free_c = c + 2;
          end else begin
            t = c + 2;
            while (!rdy_tab[t - base]) t++;
            free_c = t + 1;
            push(pa, 255, c + 2);
          end
        end
      end
      sample_en = se;
      x = xv;
      z = zv;
      tick();
    end
    sample_en = 1'b0;
    fb.fb_ready = 1'b1;
    repeat (10) tick();
    chk("rand_drop", drop_cnt, exp_drop);
    chk("rand_clip", clip_cnt, exp_clip);
    chk("rand_queue_empty", sb_q.size(), 0);

    // Reset mid-wipe: write strobe drops at once, wipe restarts at 0
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    push_wipe();
    repeat (20) tick();
    chk("pre_rst_we", fb.fb_we, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_we", fb.fb_we, 0);
    sb_q.delete();
    chk("rst2_drop", drop_cnt, 0);
    chk("rst2_clip", clip_cnt, 0);
    chk("rst2_addr", fb.fb_addr, 0);
    tick();
    push_wipe();
    rst = 1'b0;
    n = 0;
    while (!clear_done && n < 300) begin tick(); n++; end
    chk("rst2_wipe_done", clear_done, 1);
    repeat (3) tick();
    chk("final_queue_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lorenz_plotter.md
# lorenz_plotter

Consumer stage for the Lorenz integrator's state outputs. On each `sample_en` strobe it captures the current `x` and `z` samples, which are Q7.25 signed. It projects them onto the x–z plane as screen pixel coordinates, clips points that fall off-screen, and issues single-word framebuffer writes over a valid/ready handshake. After reset, or on request, it first wipes the whole framebuffer to zero.

## Interface
Parameters:
- H_RES, 640, screen width in pixels
- V_RES, 480, screen height in pixels
- ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W ≥ H_RES·V_RES
- SHIFT, 3, plot scale: one state unit equals 2^SHIFT pixels
- X_OFF, 320, pixel column for x = 0
- Z_OFF, 440, pixel row for z = 0; row = Z_OFF − scaled z
- COLOR_W, 8, pixel data width
- COLOR, 8'hFF, colour written for plotted points

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- sample_en  in  1  capture `x`/`z` this cycle
- x  in  32  signed Q7.25 state x
- z  in  32  signed Q7.25 state z
- clear_req  in  1  request a full framebuffer wipe (one-cycle pulse)
- fb_we  out  1  write valid
- fb_ready  in  1  sink accepts the write when fb_we && fb_ready
- fb_addr  out  ADDR_W  write address, row·H_RES + col
- fb_data  out  COLOR_W  write data
- busy  out  1  state ≠ IDLE
- clear_done  out  1  sticky; set when a wipe completes, cleared when a wipe starts
- drop_cnt  out  16  samples ignored because not IDLE; saturating
- clip_cnt  out  16  samples discarded as off-screen; saturating

## Operation
- FSM states: START, CLEAR, IDLE, CALC, WRITE.
- START: entered on reset.
  - Next cycle moves to CLEAR with the address counter at 0.
- CLEAR:
  - fb_we=1, fb_data=0, fb_addr=counter.
  - The counter advances only on an accepted write.
  - When address H_RES·V_RES−1 is accepted: go to IDLE and set clear_done.
- IDLE:
  - sample_en: register x and z, go to CALC.
  - Otherwise, clear_req or a pending clear: go to CLEAR with counter 0, clear_done=0.
  - sample_en has priority over clear_req; the clear is latched as pending.
- CALC:
  - xs = x >>> (25−SHIFT), zs = z >>> (25−SHIFT); arithmetic shifts, 32-bit signed.
  - col = X_OFF + xs, row = Z_OFF − zs.
  - If col ∉ [0, H_RES) or row ∉ [0, V_RES): clip_cnt++, go to IDLE, no write.
  - Else register fb_addr = row·H_RES + col and go to WRITE.
- WRITE:
  - fb_we=1, fb_data=COLOR, fb_addr held stable.
  - Go to IDLE on fb_ready.
- sample_en in any state other than IDLE: drop_cnt++. The sample is never queued.
- clear_req in any state other than IDLE: sets a pending flag, which is taken at the next IDLE.
  - clear_req during CLEAR does not restart the wipe; the pending flag is discarded on entry to CLEAR.
- Counters saturate at 16'hFFFF and are cleared only by rst.

## Timing
- Reset values: state START, fb_we 0, fb_addr 0, fb_data 0, busy 1, clear_done 0, drop_cnt 0, clip_cnt 0, pending 0.
- Reset asserted mid-write drops that write immediately (fb_we → 0 asynchronously).
- First fb_we=1 appears 2 cycles after rst deasserts (START → CLEAR).
- With fb_ready held high, a wipe takes exactly H_RES·V_RES cycles.
- Plot latency: sample_en in cycle n → fb_we=1 in cycle n+2. With fb_ready=1, back in IDLE at n+3.
  - Maximum plot rate is one sample per 3 cycles.
- fb_we, fb_addr and fb_data must not change while fb_we=1 && fb_ready=0.
- All outputs are registered or decoded from state only; none depends combinationally on sample_en, x or z.

## Structure
- Shared package `lorenz_pkg`:
  - Q-format constants (Q_INT=7, Q_FRAC=25, Q_W=32).
  - State enum.
  - Default screen constants.
- Sub-module `lorenz_pixel_map`: combinational shift, offset, clip flag and address multiply, instantiated in CALC's register stage.

## Test plan
- Reset release with H_RES=16, V_RES=8 and fb_ready=1 → writes to addresses 0..127, all data 0, in 128 consecutive cycles; then clear_done=1 and busy=0.
- Default params after wipe: x=0, z=0x32000000 (25) → one write with addr 153920 (row 240, col 320) and data 8'hFF, exactly 2 cycles after sample_en.
- x=0xFE000000 (−1), z=0x32000000 → addr 153912 (col 312).
- x=0x64000000 (50) → col 720, clipped: no write, clip_cnt=1.
- z=0x78000000 (60) → row −40, clipped: no write, clip_cnt=2.
- fb_ready low for 5 cycles during WRITE, with sample_en pulsed twice meanwhile → fb_we/addr/data stable throughout, drop_cnt=2, single write completes when fb_ready rises.
- clear_req during WRITE → after the write completes, FSM enters CLEAR from address 0 and clear_done drops to 0.
- rst asserted mid-CLEAR → fb_we falls immediately; after release, the wipe restarts at address 0.
